// File: rtl/sparc_tlu_penc_sched_if.sv
// Scheduler-side bundle: event/clear/mask inputs, offer handshake and state readback.
// master = event sources and consumer, slave = scheduler.
interface sparc_tlu_penc_sched_if #(
  parameter int NSRC = 64,
  parameter int ID_W = 6
);
  logic [NSRC-1:0] set_vec;
  logic [NSRC-1:0] clr_vec;
  logic            mask_wr_en;
  logic [NSRC-1:0] mask_wr_data;
  logic            sched_en;
  logic            req_vld;
  logic [ID_W-1:0] req_id;
  logic            ack;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;

  modport master (
    output set_vec, clr_vec, mask_wr_en, mask_wr_data, sched_en, ack,
    input  req_vld, req_id, pend, mask
  );

  modport slave (
    input  set_vec, clr_vec, mask_wr_en, mask_wr_data, sched_en, ack,
    output req_vld, req_id, pend, mask
  );
endinterface

// File: rtl/sparc_tlu_penc_sched.sv
// Pending-event scheduler: 64-bit pend/mask registers, 64->6 priority pick
// (bit 63 highest), single outstanding offer with valid/ack and withdraw.
module sparc_tlu_penc_sched #(
  parameter int NSRC = 64,
  parameter int ID_W = 6
) (
  input  logic                  rclk,
  input  logic                  reset,
  sparc_tlu_penc_sched_if.slave bus
);

  typedef enum logic {IDLE, OFFER} state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            req_vld_q, req_vld_d;
  logic [ID_W-1:0] req_id_q, req_id_d;

  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] id_oh;
  logic [NSRC-1:0] ackclr;
  logic [ID_W-1:0] penc_id;
  logic            ack_take;
  logic            live;

  assign elig = pend_q & ~mask_q;

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    penc_id = '0;
    for (int i = 0; i < NSRC; i++)
      if (elig[i]) penc_id = ID_W'(i);
  end

  assign id_oh    = NSRC'(1) << req_id_q;
  assign ack_take = req_vld_q & bus.ack;
  assign ackclr   = ack_take ? id_oh : '0;

  // Offered source still worth offering after this cycle's clear/set; lets a
  // software clear withdraw with the same one-cycle response as an ack.
  assign live = |(id_oh & ((pend_q & ~bus.clr_vec) | bus.set_vec) & ~mask_q);

  assign pend_d = (pend_q & ~bus.clr_vec & ~ackclr) | bus.set_vec;
  assign mask_d = bus.mask_wr_en ? bus.mask_wr_data : mask_q;

  always_comb begin
    state_d   = state_q;
    req_vld_d = req_vld_q;
    req_id_d  = req_id_q;
    unique case (state_q)
      IDLE: begin
        if (bus.sched_en && (|elig)) begin
          req_id_d  = penc_id;
          req_vld_d = 1'b1;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (bus.ack || !live) begin
          req_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        req_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      mask_q    <= '1;
      req_vld_q <= 1'b0;
      req_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      req_vld_q <= req_vld_d;
      req_id_q  <= req_id_d;
    end
  end

  assign bus.req_vld = req_vld_q;
  assign bus.req_id  = req_id_q;
  assign bus.pend    = pend_q;
  assign bus.mask    = mask_q;

endmodule

// File: tb/tb_sparc_tlu_penc_sched.sv
// Directed bench: per-cycle vector table of inputs and expected registered
// outputs, plus a priority sweep with bounded handshake waits.
module tb_sparc_tlu_penc_sched;

  localparam logic [63:0] ONES = '1;

  logic rclk;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;

  sparc_tlu_penc_sched_if #(.NSRC(64), .ID_W(6)) bus ();

  sparc_tlu_penc_sched #(.NSRC(64), .ID_W(6)) dut (
    .rclk  (rclk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  typedef struct {
    logic        rst;
    logic [63:0] set;
    logic [63:0] clr;
    logic        mwe;
    logic [63:0] mwd;
    logic        sen;
    logic        ack;
    logic        vld;
    logic        chk_id;
    logic [5:0]  id;
    logic [63:0] pend;
    logic [63:0] mask;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] bt(int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  task automatic add(logic rst, logic [63:0] set, logic [63:0] clr, logic mwe,
                     logic [63:0] mwd, logic sen, logic ack, logic vld,
                     logic chk_id, logic [5:0] id, logic [63:0] pend,
                     logic [63:0] mask);
    vec_t v;
    v.rst = rst; v.set = set; v.clr = clr; v.mwe = mwe; v.mwd = mwd;
    v.sen = sen; v.ack = ack; v.vld = vld; v.chk_id = chk_id; v.id = id;
    v.pend = pend; v.mask = mask;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, int tag, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s step %0d: got %h want %h", nm, tag, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic [63:0] set, logic [63:0] clr, logic mwe,
                       logic [63:0] mwd, logic sen, logic ack);
    reset            = rst;
    bus.set_vec      = set;
    bus.clr_vec      = clr;
    bus.mask_wr_en   = mwe;
    bus.mask_wr_data = mwd;
    bus.sched_en     = sen;
    bus.ack          = ack;
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Wait up to 6 cycles for an offer; expired bound counts as a failure.
  task automatic wait_offer(int tag);
    int n;
    n = 0;
    while (bus.req_vld !== 1'b1 && n < 6) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      n++;
    end
    chk("offer_timeout", tag, 64'(bus.req_vld), 64'd1);
  endtask

  logic [63:0] b0_40, b3_40;
  int lo_t[5] = '{0, 16, 31, 5, 62};
  int hi_t[5] = '{1, 17, 32, 62, 63};

  initial begin
    b0_40 = bt(0) | bt(40);
    b3_40 = bt(3) | bt(40);

    // reset, then open the mask
    add(1, 0, 0, 0, 0, 0, 0,   0, 1, 0,  0, ONES);
    add(0, 0, 0, 1, 0, 1, 0,   0, 0, 0,  0, 0);
    // 1: 40 then 3
    add(0, b3_40, 0, 0, 0, 1, 0,   0, 0, 0,  b3_40, 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 40, b3_40, 0);
    add(0, 0, 0, 0, 0, 1, 1,       0, 0, 0,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 3,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 1,       0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0, 1, 0,       0, 0, 0,  0, 0);
    // 2: no preemption by 63
    add(0, b3_40, 0, 0, 0, 1, 0,   0, 0, 0,  b3_40, 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 40, b3_40, 0);
    add(0, bt(63), 0, 0, 0, 1, 0,  1, 1, 40, b3_40 | bt(63), 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 40, b3_40 | bt(63), 0);
    add(0, 0, 0, 0, 0, 1, 1,       0, 0, 0,  bt(3) | bt(63), 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 63, bt(3) | bt(63), 0);
    add(0, 0, 0, 0, 0, 1, 1,       0, 0, 0,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 3,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 1,       0, 0, 0,  0, 0);
    // 3a: clear withdraws
    add(0, b3_40, 0, 0, 0, 1, 0,   0, 0, 0,  b3_40, 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 40, b3_40, 0);
    add(0, 0, bt(40), 0, 0, 1, 0,  0, 0, 0,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 3,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 1,       0, 0, 0,  0, 0);
    // 3b: clear plus ack
    add(0, b3_40, 0, 0, 0, 1, 0,   0, 0, 0,  b3_40, 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 40, b3_40, 0);
    add(0, 0, bt(40), 0, 0, 1, 1,  0, 0, 0,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 3,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 1,       0, 0, 0,  0, 0);
    // 4: set wins over ack
    add(0, b3_40, 0, 0, 0, 1, 0,   0, 0, 0,  b3_40, 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 40, b3_40, 0);
    add(0, bt(40), 0, 0, 0, 1, 1,  0, 0, 0,  b3_40, 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 40, b3_40, 0);
    add(0, 0, 0, 0, 0, 1, 1,       0, 0, 0,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 0,       1, 1, 3,  bt(3), 0);
    add(0, 0, 0, 0, 0, 1, 1,       0, 0, 0,  0, 0);
    // 5: mask all but bit 0; id 0 offered; elig=0 / sched_en=0 stay idle
    add(0, b0_40, 0, 1, ~bt(0), 1, 0, 0, 0, 0,  b0_40, ~bt(0));
    add(0, 0, 0, 0, 0, 1, 0,          1, 1, 0,  b0_40, ~bt(0));
    add(0, 0, 0, 0, 0, 1, 1,          0, 0, 0,  bt(40), ~bt(0));
    add(0, 0, 0, 0, 0, 1, 0,          0, 0, 0,  bt(40), ~bt(0));
    add(0, bt(0), 0, 0, 0, 0, 0,      0, 0, 0,  b0_40, ~bt(0));
    add(0, 0, 0, 0, 0, 0, 0,          0, 0, 0,  b0_40, ~bt(0));
    add(0, 0, 0, 0, 0, 0, 0,          0, 0, 0,  b0_40, ~bt(0));
    add(0, 0, 0, 0, 0, 1, 0,          1, 1, 0,  b0_40, ~bt(0));
    add(0, 0, 0, 1, ONES, 1, 0,       1, 1, 0,  b0_40, ONES);
    add(0, 0, 0, 0, 0, 1, 0,          0, 0, 0,  b0_40, ONES);
    add(0, 0, 0, 0, 0, 1, 0,          0, 0, 0,  b0_40, ONES);
    // 6: reset with ack mid-offer
    add(0, 0, 0, 1, 0, 1, 0,   0, 0, 0,  b0_40, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 1, 40, b0_40, 0);
    add(1, 0, 0, 0, 0, 1, 1,   0, 1, 0,  0, ONES);
    add(0, 0, 0, 0, 0, 1, 0,   0, 1, 0,  0, ONES);
    // sched_en low does not withdraw an offer
    add(0, 0, 0, 1, 0, 1, 0,      0, 0, 0,  0, 0);
    add(0, bt(5), 0, 0, 0, 1, 0,  0, 0, 0,  bt(5), 0);
    add(0, 0, 0, 0, 0, 1, 0,      1, 1, 5,  bt(5), 0);
    add(0, 0, 0, 0, 0, 0, 0,      1, 1, 5,  bt(5), 0);
    add(0, 0, 0, 0, 0, 0, 0,      1, 1, 5,  bt(5), 0);
    add(0, 0, 0, 0, 0, 0, 1,      0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0, 1, 0,      0, 0, 0,  0, 0);

    drive(1, 0, 0, 0, 0, 0, 0);
    #2;
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].set, tbl[k].clr, tbl[k].mwe, tbl[k].mwd,
            tbl[k].sen, tbl[k].ack);
      tick();
      chk("req_vld", k, 64'(bus.req_vld), 64'(tbl[k].vld));
      chk("pend", k, bus.pend, tbl[k].pend);
      chk("mask", k, bus.mask, tbl[k].mask);
      if (tbl[k].chk_id) chk("req_id", k, 64'(bus.req_id), 64'(tbl[k].id));
    end

    // priority sweep: higher of each pair first, then the lower
    for (int p = 0; p < 5; p++) begin
      drive(0, bt(lo_t[p]) | bt(hi_t[p]), 0, 0, 0, 1, 0);
      tick();
      wait_offer(100 + p);
      chk("sweep_hi", 100 + p, 64'(bus.req_id), 64'(hi_t[p]));
      drive(0, 0, 0, 0, 0, 1, 1);
      tick();
      chk("sweep_ack_vld", 100 + p, 64'(bus.req_vld), 64'd0);
      wait_offer(200 + p);
      chk("sweep_lo", 200 + p, 64'(bus.req_id), 64'(lo_t[p]));
      drive(0, 0, 0, 0, 0, 1, 1);
      tick();
      chk("sweep_pend", 200 + p, bus.pend, 64'd0);
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
